// File: rtl/md_sched_if.sv
// E/D-stage signal bundle between the pipeline and the multiply/divide scheduler.
interface md_sched_if;
    logic [3:0]  c_mdop_E;
    logic [31:0] v_A_E;
    logic [31:0] v_B_E;
    logic        c_MD_D;
    logic [31:0] v_md_E;
    logic        busy;
    logic        h_MD_stall;

    modport master (
        output c_mdop_E, v_A_E, v_B_E, c_MD_D,
        input  v_md_E, busy, h_MD_stall
    );

    modport slave (
        input  c_mdop_E, v_A_E, v_B_E, c_MD_D,
        output v_md_E, busy, h_MD_stall
    );
endinterface

// File: rtl/md_sched.sv
// Multiply/divide scheduler: multi-cycle HI/LO unit with busy tracking and D-stage stall request.
// Optional feature macro: MDU_MADD_EN (enables madd/maddu, ops 9 and 10).
module md_sched #(
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 10
) (
    input  logic      clk,
    input  logic      reset,
    md_sched_if.slave md
);
    localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CW      = $clog2(MAX_LAT + 1);

    typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_e;

    state_e        state_q;
    logic [CW-1:0] cnt_q;
    logic [31:0]   hi_q, lo_q, pend_hi_q, pend_lo_q;
    logic          pend_wr_q;

    logic          is_mul_s, is_div_s, is_madd_s, sgn_s, start_s, busy_s;
    logic [63:0]   pend_d;
    logic          pend_wr_d;

    // Sign/zero-extend to 64 bits; the low 64 product bits are exact for both cases.
    function automatic logic [63:0] mul_f(input logic [31:0] a, input logic [31:0] b,
                                          input logic sgn);
        logic [63:0] ax, bx;
        ax = {(sgn ? {32{a[31]}} : 32'h0000_0000), a};
        bx = {(sgn ? {32{b[31]}} : 32'h0000_0000), b};
        return ax * bx;
    endfunction

    // Magnitude divide then re-sign; returns {rem, quot}. 0x80000000/-1 falls out naturally.
    function automatic logic [63:0] div_f(input logic [31:0] a, input logic [31:0] b,
                                          input logic sgn);
        logic [31:0] ua, ub, q, r;
        ua = (sgn & a[31]) ? (32'h0000_0000 - a) : a;
        ub = (sgn & b[31]) ? (32'h0000_0000 - b) : b;
        if (ub == 32'h0000_0000) begin
            q = 32'h0000_0000;
            r = 32'h0000_0000;
        end else begin
            q = ua / ub;
            r = ua % ub;
        end
        if (sgn & (a[31] ^ b[31])) q = 32'h0000_0000 - q;
        else                       q = q;
        if (sgn & a[31]) r = 32'h0000_0000 - r;
        else             r = r;
        return {r, q};
    endfunction

    // Decode the E-stage op class.
    always_comb begin
        is_mul_s  = 1'b0;
        is_div_s  = 1'b0;
        is_madd_s = 1'b0;
        sgn_s     = 1'b0;
        case (md.c_mdop_E)
            4'd1:    begin is_mul_s = 1'b1; sgn_s = 1'b1; end
            4'd2:    is_mul_s = 1'b1;
            4'd3:    begin is_div_s = 1'b1; sgn_s = 1'b1; end
            4'd4:    is_div_s = 1'b1;
`ifdef MDU_MADD_EN
            4'd9:    begin is_madd_s = 1'b1; sgn_s = 1'b1; end
            4'd10:   is_madd_s = 1'b1;
`endif
            default: is_mul_s = 1'b0;
        endcase
    end

    assign busy_s  = (cnt_q != '0);
    assign start_s = (is_mul_s | is_div_s | is_madd_s) & ~busy_s;

    // Pending result; a zero divisor suppresses the commit but still occupies the unit.
    always_comb begin
        pend_d    = 64'h0;
        pend_wr_d = 1'b1;
        if (is_div_s) begin
            pend_d    = div_f(md.v_A_E, md.v_B_E, sgn_s);
            pend_wr_d = (md.v_B_E != 32'h0000_0000);
        end else if (is_madd_s) begin
            pend_d = {hi_q, lo_q} + mul_f(md.v_A_E, md.v_B_E, sgn_s);
        end else begin
            pend_d = mul_f(md.v_A_E, md.v_B_E, sgn_s);
        end
    end

    // Scheduler FSM: start, count down, commit on the final busy edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            hi_q      <= 32'h0000_0000;
            lo_q      <= 32'h0000_0000;
            pend_hi_q <= 32'h0000_0000;
            pend_lo_q <= 32'h0000_0000;
            pend_wr_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_s) begin
                        state_q   <= S_RUN;
                        cnt_q     <= is_div_s ? CW'(DIV_LAT) : CW'(MUL_LAT);
                        pend_hi_q <= pend_d[63:32];
                        pend_lo_q <= pend_d[31:0];
                        pend_wr_q <= pend_wr_d;
                    end else if (md.c_mdop_E == 4'd7) begin
                        hi_q <= md.v_A_E;
                    end else if (md.c_mdop_E == 4'd8) begin
                        lo_q <= md.v_A_E;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_RUN: begin
                    if (cnt_q == CW'(1)) begin
                        state_q <= S_IDLE;
                        cnt_q   <= '0;
                        if (pend_wr_q) begin
                            hi_q <= pend_hi_q;
                            lo_q <= pend_lo_q;
                        end else begin
                            hi_q <= hi_q;
                        end
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    // HI/LO read port; suppressed while busy or in reset.
    always_comb begin
        md.v_md_E = 32'h0000_0000;
        if (!reset || busy_s)               md.v_md_E = 32'h0000_0000;
        else if (md.c_mdop_E == 4'd5)       md.v_md_E = hi_q;
        else if (md.c_mdop_E == 4'd6)       md.v_md_E = lo_q;
        else                                md.v_md_E = 32'h0000_0000;
    end

    assign md.busy       = busy_s;
    assign md.h_MD_stall = md.c_MD_D & (busy_s | start_s);
endmodule

// File: tb/tb_md_sched.sv
// Self-checking bench for md_sched: directed vector table plus randomized run against a reference model.
module tb_md_sched;
    logic clk;
    logic reset;
    md_sched_if mif();

    md_sched dut (.clk(clk), .reset(reset), .md(mif));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a, b;
        bit          cmd, rst;
        logic [31:0] ev;
        bit          eb, es;
        bit [2:0]    mask;   // {v, busy, stall} checks enabled
    } vec_t;
    vec_t vecs[$];

    // Reference model state
    int          m_rem = 0;
    logic [31:0] m_hi = 0, m_lo = 0, m_phi = 0, m_plo = 0;
    bit          m_pv = 0;

    function automatic bit starts(input logic [3:0] op);
        if (op >= 4'd1 && op <= 4'd4) return 1'b1;
`ifdef MDU_MADD_EN
        if (op == 4'd9 || op == 4'd10) return 1'b1;
`endif
        return 1'b0;
    endfunction

    task automatic model_step(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                              input bit cmd, input bit rst,
                              output logic [31:0] ev, output bit eb, output bit es);
        bit st;
        longint sa, sb, q, r;
        logic [63:0] p;
        eb = (m_rem != 0);
        st = starts(op) && !eb;
        es = cmd && (eb || st);
        ev = 32'h0;
        if (rst && !eb && op == 4'd5) ev = m_hi;
        if (rst && !eb && op == 4'd6) ev = m_lo;
        if (!rst) begin
            m_rem = 0; m_hi = 0; m_lo = 0; m_pv = 0;
        end else if (eb) begin
            m_rem--;
            if (m_rem == 0 && m_pv) begin m_hi = m_phi; m_lo = m_plo; end
        end else if (st) begin
            m_pv  = 1'b1;
            m_rem = (op == 4'd3 || op == 4'd4) ? 10 : 5;
            if (op == 4'd1 || op == 4'd9) begin
                sa = longint'($signed(a)); sb = longint'($signed(b));
                p = sa * sb;
            end else begin
                p = {32'h0, a} * {32'h0, b};
            end
            if (op == 4'd9 || op == 4'd10) p = p + {m_hi, m_lo};
            if (op == 4'd3 || op == 4'd4) begin
                if (op == 4'd3) begin
                    sa = longint'($signed(a)); sb = longint'($signed(b));
                end else begin
                    sa = longint'({32'h0, a}); sb = longint'({32'h0, b});
                end
                if (sb == 0) begin
                    m_pv = 1'b0;
                end else begin
                    q = sa / sb; r = sa % sb;
                    p = {r[31:0], q[31:0]};
                end
            end
            m_phi = p[63:32]; m_plo = p[31:0];
        end else if (op == 4'd7) begin
            m_hi = a;
        end else if (op == 4'd8) begin
            m_lo = a;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_tests++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp_v);
        end
    endtask

    // One cycle: drive after negedge, sample mid-low-phase, advance the model.
    task automatic cyc(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input bit cmd, input bit rst,
                       output logic [31:0] av, output bit ab, output bit as_,
                       output logic [31:0] mv, output bit mb, output bit ms);
        @(negedge clk);
        mif.c_mdop_E = op; mif.v_A_E = a; mif.v_B_E = b; mif.c_MD_D = cmd; reset = rst;
        #2;
        av = mif.v_md_E; ab = mif.busy; as_ = mif.h_MD_stall;
        model_step(op, a, b, cmd, rst, mv, mb, ms);
    endtask

    task automatic add(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input bit cmd, input bit rst, input logic [31:0] ev,
                       input bit eb, input bit es, input bit [2:0] mask);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.cmd = cmd; v.rst = rst;
        v.ev = ev; v.eb = eb; v.es = es; v.mask = mask;
        vecs.push_back(v);
    endtask

    task automatic add_busy(input int n, input bit cmd);
        for (int i = 0; i < n; i++) add(4'd0, 32'h0, 32'h0, cmd, 1'b1, 32'h0, 1'b1, cmd, 3'b111);
    endtask

    logic [31:0] av, mv;
    bit ab, as_, mb, ms;

    initial begin
        reset = 1'b0;
        mif.c_mdop_E = 4'd0; mif.v_A_E = 32'h0; mif.v_B_E = 32'h0; mif.c_MD_D = 1'b0;

        // reset behaviour
        add(4'd0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 3'b111);
        add(4'd1, 32'h5, 32'h6, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 3'b111);
        add(4'd5, 32'h0, 32'h0, 1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 3'b111);
        // mult -2*3 with MD op waiting in D
        add(4'd1, 32'hFFFF_FFFE, 32'h3, 1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 3'b111);
        add_busy(5, 1'b1);
        add(4'd5, 32'h0, 32'h0, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 3'b111);
        add(4'd6, 32'h0, 32'h0, 1'b0, 1'b1, 32'hFFFF_FFFA, 1'b0, 1'b0, 3'b111);
        // multu same operands
        add(4'd2, 32'hFFFF_FFFE, 32'h3, 1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 3'b111);
        add_busy(5, 1'b0);
        add(4'd5, 32'h0, 32'h0, 1'b0, 1'b1, 32'h0000_0002, 1'b0, 1'b0, 3'b111);
        add(4'd6, 32'h0, 32'h0, 1'b0, 1'b1, 32'hFFFF_FFFA, 1'b0, 1'b0, 3'b111);
        // div -7/2, mflo in D stalls from the start cycle
        add(4'd3, 32'hFFFF_FFF9, 32'h2, 1'b1, 1'b1, 32'h0, 1'b0, 1'b1, 3'b111);
        add_busy(10, 1'b1);
        add(4'd6, 32'h0, 32'h0, 1'b1, 1'b1, 32'hFFFF_FFFD, 1'b0, 1'b0, 3'b111);
        add(4'd5, 32'h0, 32'h0, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 3'b111);
        // divu by zero leaves HI/LO
        add(4'd4, 32'h7, 32'h0, 1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 3'b111);
        add_busy(10, 1'b0);
        add(4'd5, 32'h0, 32'h0, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 3'b111);
        add(4'd6, 32'h0, 32'h0, 1'b0, 1'b1, 32'hFFFF_FFFD, 1'b0, 1'b0, 3'b111);
        // signed overflow divide
        add(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 3'b111);
        add_busy(10, 1'b0);
        add(4'd6, 32'h0, 32'h0, 1'b0, 1'b1, 32'h8000_0000, 1'b0, 1'b0, 3'b111);
        add(4'd5, 32'h0, 32'h0, 1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 3'b111);
        // mthi/mtlo back-to-back
        add(4'd7, 32'h1234, 32'h0, 1'b1, 1'b1, 32'h0, 1'b0, 1'b0, 3'b111);
        add(4'd8, 32'h5678, 32'h0, 1'b1, 1'b1, 32'h0, 1'b0, 1'b0, 3'b111);
        add(4'd5, 32'h0, 32'h0, 1'b0, 1'b1, 32'h1234, 1'b0, 1'b0, 3'b111);
        add(4'd6, 32'h0, 32'h0, 1'b0, 1'b1, 32'h5678, 1'b0, 1'b0, 3'b111);
        // reset during mult aborts it
        add(4'd1, 32'h3, 32'h3, 1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 3'b111);
        add_busy(2, 1'b0);
        add(4'd0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 3'b101);
        for (int i = 0; i < 6; i++)
            add(4'd5, 32'h0, 32'h0, 1'b1, 1'b1, 32'h0, 1'b0, 1'b0, 3'b111);
        add(4'd6, 32'h0, 32'h0, 1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 3'b111);
`ifdef MDU_MADD_EN
        add(4'd8, 32'h1, 32'h0, 1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 3'b111);
        add(4'd9, 32'h2, 32'h3, 1'b1, 1'b1, 32'h0, 1'b0, 1'b1, 3'b111);
        add_busy(5, 1'b1);
        add(4'd6, 32'h0, 32'h0, 1'b0, 1'b1, 32'h7, 1'b0, 1'b0, 3'b111);
        add(4'd5, 32'h0, 32'h0, 1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 3'b111);
`else
        add(4'd9, 32'h2, 32'h3, 1'b1, 1'b1, 32'h0, 1'b0, 1'b0, 3'b111);
        add(4'd10, 32'h2, 32'h3, 1'b1, 1'b1, 32'h0, 1'b0, 1'b0, 3'b111);
        add(4'd6, 32'h0, 32'h0, 1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 3'b111);
`endif

        foreach (vecs[i]) begin
            cyc(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].cmd, vecs[i].rst, av, ab, as_, mv, mb, ms);
            if (vecs[i].mask[2]) chk($sformatf("vec%0d v_md_E", i), av, vecs[i].ev);
            if (vecs[i].mask[1]) chk($sformatf("vec%0d busy", i), {31'h0, ab}, {31'h0, vecs[i].eb});
            if (vecs[i].mask[0]) chk($sformatf("vec%0d stall", i), {31'h0, as_}, {31'h0, vecs[i].es});
        end

        // Randomized run against the reference model
        cyc(4'd0, 32'h0, 32'h0, 1'b0, 1'b0, av, ab, as_, mv, mb, ms);
        for (int i = 0; i < 1500; i++) begin
            logic [3:0]  op;
            logic [31:0] a, b;
            bit cmd, rst;
            op  = 4'($urandom_range(0, 15));
            a   = $urandom;
            b   = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'h0;
                1: b = 32'hFFFF_FFFF;
                2: a = 32'h8000_0000;
                3: b = 32'($urandom_range(1, 9));
                default: ;
            endcase
            cmd = 1'($urandom_range(0, 1));
            rst = ($urandom_range(0, 59) != 0);
            cyc(op, a, b, cmd, rst, av, ab, as_, mv, mb, ms);
            chk($sformatf("rnd%0d v_md_E", i), av, mv);
            chk($sformatf("rnd%0d busy", i), {31'h0, ab}, {31'h0, mb});
            chk($sformatf("rnd%0d stall", i), {31'h0, as_}, {31'h0, ms});
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
